// File: rtl/ram_dp_sync_param.sv
// Parametrised synchronous simple-dual-port RAM: one write port and one read port on one clock.
// After reset the array is cleared by a sweep of DEPTH cycles, during which accesses are ignored.
// Reads have a latency of 1 cycle, or 2 cycles with OUT_REG. rd_valid marks each new result.
// Same-address read-during-write returns old data (RDW_MODE=0) or the incoming data (RDW_MODE=1).
// Addresses >= DEPTH never touch the array; they raise a one-cycle addr_err pulse.
module ram_dp_sync_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              We,
  input  logic [ADDR_W-1:0] Wr_addr,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              Re,
  input  logic [ADDR_W-1:0] Rd_addr,
  output logic [WIDTH-1:0]  data_out,
  output logic              rd_valid,
  output logic              init_busy,
  output logic              addr_err
);

  // The array index only needs enough bits for DEPTH entries. In-range addresses fit in it.
  localparam int unsigned   IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DepthL   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StInit, StReady} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_busy_q;

  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              ready;
  logic              wr_ok;
  logic              rd_ok;
  logic              rd_fire;
  logic [WIDTH-1:0]  rd_word;

  logic              mem_we;
  logic [IdxW-1:0]   mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic              v1_q;
  logic [WIDTH-1:0]  d1_q;
  logic              err_q;

  assign ready   = (state_q == StReady);
  assign wr_ok   = ({1'b0, Wr_addr} < DepthL);
  assign rd_ok   = ({1'b0, Rd_addr} < DepthL);
  assign rd_fire = ready && Re;

  // Clear-sweep FSM: counts through every address once, then enables accesses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        StInit: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == LastAddr) begin
            state_q     <= StReady;
            init_busy_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        StReady: begin
          state_q <= StReady;
        end
        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

  // Array write port: the sweep owns it during init, the user port afterwards.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q[IdxW-1:0];
    mem_wdata = '0;
    if (!ready) begin
      mem_we = 1'b1;
    end else if (We && wr_ok) begin
      mem_we    = 1'b1;
      mem_waddr = Wr_addr[IdxW-1:0];
      mem_wdata = data_in;
    end
  end

  // Array storage; deliberately not reset, the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read word selection, including the out-of-range zero and the same-address bypass.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      if ((RDW_MODE != 0) && We && (Wr_addr == Rd_addr)) begin
        rd_word = data_in;
      end else begin
        rd_word = mem_q[Rd_addr[IdxW-1:0]];
      end
    end
  end

  // First read stage and address error strobe; data holds when no read fires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= 1'b0;
      d1_q  <= '0;
      err_q <= 1'b0;
    end else begin
      v1_q  <= rd_fire;
      err_q <= ready && ((We && !wr_ok) || (Re && !rd_ok));
      if (rd_fire) begin
        d1_q <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             v2_q;
    logic [WIDTH-1:0] d2_q;

    // Optional output stage; forwards each result one cycle later and holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q <= d1_q;
        end
      end
    end

    assign data_out = d2_q;
    assign rd_valid = v2_q;
  end else begin : g_no_out_reg
    assign data_out = d1_q;
    assign rd_valid = v1_q;
  end

  assign init_busy = init_busy_q;
  assign addr_err  = err_q;

endmodule

// File: tb/tb_ram_dp_sync_param.sv
// Bench for ram_dp_sync_param. Two instances share one stimulus stream:
// instance 0 uses old-data collisions with 1-cycle latency,
// instance 1 uses bypass collisions with 2-cycle latency.
// A behavioural model predicts every output after every clock edge.
module tb_ram_dp_sync_param;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 12;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] wa;
  logic [W-1:0]  din;
  logic          re;
  logic [AW-1:0] ra;

  logic [W-1:0]  dout_a, dout_b;
  logic          val_a, val_b;
  logic          busy_a, busy_b;
  logic          err_a, err_b;

  int checks;
  int errors;

  ram_dp_sync_param #(
    .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .We(we), .Wr_addr(wa), .data_in(din), .Re(re), .Rd_addr(ra),
    .data_out(dout_a), .rd_valid(val_a), .init_busy(busy_a), .addr_err(err_a)
  );

  ram_dp_sync_param #(
    .WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .We(we), .Wr_addr(wa), .data_in(din), .Re(re), .Rd_addr(ra),
    .data_out(dout_b), .rd_valid(val_b), .init_busy(busy_b), .addr_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one copy per instance.
  logic [W-1:0] m_mem [2][16];
  int           m_left [2];
  logic         m_hv [2][2];
  logic [W-1:0] m_hd [2][2];
  logic [W-1:0] m_out [2];
  logic         m_val [2];
  logic         m_err [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reset loses everything; the sweep leaves the whole array at zero.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = D;
      m_out[k]  = '0;
      m_val[k]  = 1'b0;
      m_err[k]  = 1'b0;
      for (int j = 0; j < 2; j++) begin
        m_hv[k][j] = 1'b0;
        m_hd[k][j] = '0;
      end
      for (int a = 0; a < 16; a++) m_mem[k][a] = '0;
    end
  endtask

  // Effect of one rising edge with the current inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic         rv;
      logic [W-1:0] rd;
      int           lat;
      rv  = 1'b0;
      rd  = '0;
      lat = k + 1;
      if (m_left[k] > 0) begin
        m_left[k]--;
        m_err[k] = 1'b0;
      end else begin
        m_err[k] = (we && (int'(wa) >= D)) || (re && (int'(ra) >= D));
        if (re) begin
          rv = 1'b1;
          if (int'(ra) < D) begin
            if (k == 1 && we && wa == ra) rd = din;
            else                          rd = m_mem[k][ra];
          end
        end
        if (we && int'(wa) < D) m_mem[k][wa] = din;
      end
      m_hv[k][1] = m_hv[k][0];
      m_hd[k][1] = m_hd[k][0];
      m_hv[k][0] = rv;
      m_hd[k][0] = rd;
      m_val[k]   = m_hv[k][lat-1];
      if (m_hv[k][lat-1]) m_out[k] = m_hd[k][lat-1];
    end
  endtask

  task automatic compare();
    check("a init_busy", 64'(busy_a), 64'(m_left[0] > 0));
    check("a rd_valid",  64'(val_a),  64'(m_val[0]));
    check("a data_out",  64'(dout_a), 64'(m_out[0]));
    check("a addr_err",  64'(err_a),  64'(m_err[0]));
    check("b init_busy", 64'(busy_b), 64'(m_left[1] > 0));
    check("b rd_valid",  64'(val_b),  64'(m_val[1]));
    check("b data_out",  64'(dout_b), 64'(m_out[1]));
    check("b addr_err",  64'(err_b),  64'(m_err[1]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic drive(input logic w, input int wad, input int d, input logic r, input int rad);
    we  = w;
    wa  = AW'(wad);
    din = W'(d);
    re  = r;
    ra  = AW'(rad);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    we = 1'b0; wa = '0; din = '0; re = 1'b0; ra = '0;

    // Asynchronous reset values.
    #3 rst = 1'b0;
    model_reset();
    #1 compare();
    @(posedge clk);
    @(posedge clk);
    #1 compare();
    rst = 1'b1;

    // Sweep: a write of 0xFF to address 0 and random reads must be ignored.
    for (int i = 0; i < int'(D); i++) drive(1'b1, 0, 8'hFF, 1'($urandom_range(0, 1)), i);
    idle(1);

    // Every address reads back zero, back-to-back.
    for (int a = 0; a < int'(D); a++) drive(1'b0, 0, 0, 1'b1, a);
    idle(3);

    // Simple write then read.
    drive(1'b1, 11, 8'hA5, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b1, 11);
    idle(3);

    // Same-address collision.
    drive(1'b1, 3, 8'h11, 1'b0, 0);
    drive(1'b1, 3, 8'h22, 1'b1, 3);
    drive(1'b0, 0, 0, 1'b1, 3);
    idle(3);

    // Out of range write and read, then check for aliasing.
    drive(1'b1, 13, 8'h7E, 1'b0, 0);
    idle(1);
    drive(1'b0, 0, 0, 1'b1, 14);
    idle(1);
    drive(1'b1, 15, 8'h3C, 1'b1, 12);
    drive(1'b0, 0, 0, 1'b1, 1);
    drive(1'b0, 0, 0, 1'b1, 2);
    drive(1'b0, 0, 0, 1'b1, 0);
    idle(3);

    // Random traffic over the whole address space, collisions included.
    for (int i = 0; i < 600; i++) begin
      int r_wa;
      int r_ra;
      r_wa = $urandom_range(0, 15);
      r_ra = ($urandom_range(0, 3) == 0) ? r_wa : $urandom_range(0, 15);
      drive(1'($urandom_range(0, 1)), r_wa, $urandom_range(0, 255),
            1'($urandom_range(0, 1)), r_ra);
    end
    idle(3);

    // Reset while a read is in flight.
    drive(1'b1, 11, 8'hA5, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b1, 11);
    we = 1'b0; re = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1 compare();
    @(posedge clk);
    @(posedge clk);
    #1 compare();
    rst = 1'b1;
    idle(D);
    drive(1'b0, 0, 0, 1'b1, 11);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
